// File: rtl/operand_bypass_collector.sv
// operand_bypass_collector: forwarding-network operand select and busy scoreboard (BYPASS_PERF_CNT_EN adds perf counters)
module operand_bypass_collector #(
   parameter int UNIT_ID_SIZE   = 3,
   parameter int REG_ADDR_WIDTH = 7,
   parameter int QUADWORD       = 128,
   parameter int PKT_W          = UNIT_ID_SIZE + 1 + REG_ADDR_WIDTH + QUADWORD,
   parameter int N_FWE          = 6,
   parameter int N_FWO          = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_FWE*PKT_W-1:0]        fwe,
   input  logic [N_FWO*PKT_W-1:0]        fwo,
   input  logic [PKT_W-1:0]              wb_even,
   input  logic [PKT_W-1:0]              wb_odd,
   input  logic                          rd_valid,
   input  logic [5*REG_ADDR_WIDTH-1:0]   src_addr,
   input  logic [5*QUADWORD-1:0]         rf_data,
   input  logic                          iss_we_even,
   input  logic                          iss_we_odd,
   input  logic [REG_ADDR_WIDTH-1:0]     iss_rt_even,
   input  logic [REG_ADDR_WIDTH-1:0]     iss_rt_odd,
   output logic                          stall,
   output logic                          op_valid,
   output logic [QUADWORD-1:0]           ra_rd_even,
   output logic [QUADWORD-1:0]           rb_rd_even,
   output logic [QUADWORD-1:0]           rc_rd_even,
   output logic [QUADWORD-1:0]           ra_rd_odd,
   output logic [QUADWORD-1:0]           rb_rd_odd
`ifdef BYPASS_PERF_CNT_EN
   ,
   output logic [31:0]                   stall_cycles,
   output logic [31:0]                   fwd_hits
`endif
);
   localparam int NREG = 1 << REG_ADDR_WIDTH;
   localparam int NF   = N_FWE + N_FWO;
   localparam int NP   = NF + 2;
   localparam int RAW  = REG_ADDR_WIDTH;
   // pk is in priority order: index 0 highest, wb_odd lowest
   logic [PKT_W-1:0]    pk [NP];
   logic [NREG-1:0]     busy_q, busy_d;
   logic [QUADWORD-1:0] ops_q [5];
   logic [QUADWORD-1:0] ops_d [5];
   logic [QUADWORD-1:0] sel [5];
   logic [4:0]          hit, fwd, hazard;
   logic                op_valid_q, op_valid_d, capture, unused_bits;
   for (genvar i = 0; i < N_FWE; i++) begin : g_fwe
      assign pk[i < N_FWO ? 2*i : N_FWO + i] = fwe[i*PKT_W +: PKT_W];
   end
   for (genvar i = 0; i < N_FWO; i++) begin : g_fwo
      assign pk[2*i + 1] = fwo[i*PKT_W +: PKT_W];
   end
   assign pk[NP-2] = wb_even;
   assign pk[NP-1] = wb_odd;
   always_comb begin
      for (int k = 0; k < 5; k++) begin
         sel[k] = rf_data[k*QUADWORD +: QUADWORD];
         hit[k] = 1'b0;
         fwd[k] = 1'b0;
         for (int p = NP - 1; p >= 0; p--) begin
            if (pk[p][QUADWORD+RAW] && pk[p][QUADWORD +: RAW] == src_addr[k*RAW +: RAW]) begin
               sel[k] = pk[p][QUADWORD-1:0];
               hit[k] = 1'b1;
               fwd[k] = p < NF;
            end
         end
         hazard[k] = busy_q[src_addr[k*RAW +: RAW]] & ~hit[k];
      end
      stall      = rd_valid & (|hazard);
      capture    = rd_valid & ~stall;
      op_valid_d = capture;
      for (int k = 0; k < 5; k++) ops_d[k] = capture ? sel[k] : ops_q[k];
      busy_d = busy_q;
      if (wb_even[QUADWORD+RAW]) busy_d[wb_even[QUADWORD +: RAW]] = 1'b0;
      if (wb_odd[QUADWORD+RAW]) busy_d[wb_odd[QUADWORD +: RAW]] = 1'b0;
      // sets after clears so a same-cycle set on the same register wins
      if (capture && iss_we_even) busy_d[iss_rt_even] = 1'b1;
      if (capture && iss_we_odd) busy_d[iss_rt_odd] = 1'b1;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q     <= '0;
         op_valid_q <= 1'b0;
         for (int k = 0; k < 5; k++) ops_q[k] <= '0;
      end else begin
         busy_q     <= busy_d;
         op_valid_q <= op_valid_d;
         for (int k = 0; k < 5; k++) ops_q[k] <= ops_d[k];
      end
   end
   assign op_valid   = op_valid_q;
   assign ra_rd_even = ops_q[4];
   assign rb_rd_even = ops_q[3];
   assign rc_rd_even = ops_q[2];
   assign ra_rd_odd  = ops_q[1];
   assign rb_rd_odd  = ops_q[0];
`ifdef BYPASS_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d, fwd_hits_q, fwd_hits_d;
   logic [32:0] fwd_sum;
   always_comb begin
      stall_cycles_d = (stall && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
      fwd_sum        = {1'b0, fwd_hits_q} + 33'(capture ? $countones(fwd) : 0);
      fwd_hits_d     = fwd_sum[32] ? '1 : fwd_sum[31:0];
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles_q <= '0;
         fwd_hits_q     <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         fwd_hits_q     <= fwd_hits_d;
      end
   end
   assign stall_cycles = stall_cycles_q;
   assign fwd_hits     = fwd_hits_q;
`endif
   always_comb begin
      unused_bits = 1'b0;
      for (int p = 0; p < NP; p++) unused_bits = unused_bits ^ (^pk[p][PKT_W-1 -: UNIT_ID_SIZE]);
`ifndef BYPASS_PERF_CNT_EN
      unused_bits = unused_bits ^ (^fwd);
`endif
   end
endmodule

// File: tb/tb_operand_bypass_collector.sv
// tb_operand_bypass_collector: directed checks of operand selection, scoreboard and stall
module tb_operand_bypass_collector;
   localparam int UID = 3, RAW = 7, Q = 128, PW = UID + 1 + RAW + Q, NE = 6, NO = 5;
   logic clk = 1'b0, reset = 1'b0;
   logic [NE*PW-1:0] fwe = '0;
   logic [NO*PW-1:0] fwo = '0;
   logic [PW-1:0] wb_even = '0, wb_odd = '0;
   logic rd_valid = 1'b0, iss_we_even = 1'b0, iss_we_odd = 1'b0;
   logic [5*RAW-1:0] src_addr = '0;
   logic [5*Q-1:0] rf_data = '0;
   logic [RAW-1:0] iss_rt_even = '0, iss_rt_odd = '0;
   logic stall, op_valid;
   logic [Q-1:0] ra_rd_even, rb_rd_even, rc_rd_even, ra_rd_odd, rb_rd_odd;
   int total = 0, passed = 0;
`ifdef BYPASS_PERF_CNT_EN
   logic [31:0] stall_cycles, fwd_hits;
`endif
   operand_bypass_collector dut (
      .clk(clk), .reset(reset), .fwe(fwe), .fwo(fwo), .wb_even(wb_even), .wb_odd(wb_odd),
      .rd_valid(rd_valid), .src_addr(src_addr), .rf_data(rf_data),
      .iss_we_even(iss_we_even), .iss_we_odd(iss_we_odd),
      .iss_rt_even(iss_rt_even), .iss_rt_odd(iss_rt_odd),
      .stall(stall), .op_valid(op_valid),
      .ra_rd_even(ra_rd_even), .rb_rd_even(rb_rd_even), .rc_rd_even(rc_rd_even),
      .ra_rd_odd(ra_rd_odd), .rb_rd_odd(rb_rd_odd)
`ifdef BYPASS_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .fwd_hits(fwd_hits)
`endif
   );
   always #5 clk = ~clk;
   function automatic logic [PW-1:0] pkt(input logic [RAW-1:0] a, input logic [Q-1:0] d);
      return {3'd5, 1'b1, a, d};
   endfunction
   task automatic check(input string tag, input logic [Q-1:0] obs, input logic [Q-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clr_taps();
      fwe = '0;
      fwo = '0;
      wb_even = '0;
      wb_odd = '0;
   endtask
   initial begin
      src_addr = {7'd5, 7'd6, 7'd7, 7'd8, 7'd9};
      rf_data  = {128'h11, 128'h22, 128'h33, 128'h44, 128'h55};
      tick();
      check("rst_op_valid", op_valid, 0);
      check("rst_ra_e", ra_rd_even, 0);
      check("rst_rb_o", rb_rd_odd, 0);
      reset = 1'b1;
      tick();
      rd_valid = 1'b1;
      iss_we_even = 1'b1;
      iss_rt_even = 7'd10;
      #1 check("rf_stall", stall, 0);
      tick();
      check("rf_op_valid", op_valid, 1);
      check("rf_ra_e", ra_rd_even, 128'h11);
      check("rf_rb_e", rb_rd_even, 128'h22);
      check("rf_rc_e", rc_rd_even, 128'h33);
      check("rf_ra_o", ra_rd_odd, 128'h44);
      check("rf_rb_o", rb_rd_odd, 128'h55);
      iss_we_even = 1'b0;
      src_addr = {7'd10, 7'd6, 7'd7, 7'd8, 7'd9};
      #1 check("busy_stall", stall, 1);
      tick();
      check("busy_stall_held", stall, 1);
      check("stall_op_valid", op_valid, 0);
      check("stall_hold_ra_e", ra_rd_even, 128'h11);
      fwe[3*PW +: PW] = pkt(7'd10, {8{16'hAAAA}});
      #1 check("fwd3_unstall", stall, 0);
      tick();
      check("fwd3_op_valid", op_valid, 1);
      check("fwd3_ra_e", ra_rd_even, {8{16'hAAAA}});
      check("fwd3_rb_e", rb_rd_even, 128'h22);
      clr_taps();
      src_addr = {7'd12, 7'd12, 7'd7, 7'd8, 7'd9};
      fwe[2*PW +: PW] = pkt(7'd12, 128'hA1);
      fwo[2*PW +: PW] = pkt(7'd12, 128'hB2);
      fwe[0 +: PW]    = pkt(7'd12, 128'hC3);
      tick();
      check("prio_youngest_ra", ra_rd_even, 128'hC3);
      check("prio_youngest_rb", rb_rd_even, 128'hC3);
      fwe[0 +: PW] = '0;
      tick();
      check("prio_even_over_odd", ra_rd_even, 128'hA1);
      fwe[2*PW +: PW] = '0;
      fwo[0 +: PW] = pkt(7'd12, 128'hB0);
      fwe[1*PW +: PW] = pkt(7'd12, 128'hA9);
      tick();
      check("prio_fwo0_over_fwe1", ra_rd_even, 128'hB0);
      clr_taps();
      src_addr = {7'd5, 7'd6, 7'd7, 7'd13, 7'd9};
      fwe[5*PW +: PW] = pkt(7'd13, 128'hF6);
      wb_even = pkt(7'd13, 128'hD4);
      wb_odd  = pkt(7'd13, 128'hE5);
      tick();
      check("prio_fwe5_over_wb", ra_rd_odd, 128'hF6);
      fwe[5*PW +: PW] = '0;
      tick();
      check("prio_wbe_over_wbo", ra_rd_odd, 128'hD4);
      wb_even = '0;
      tick();
      check("prio_wbo_over_rf", ra_rd_odd, 128'hE5);
      clr_taps();
      src_addr = {7'd5, 7'd6, 7'd7, 7'd8, 7'd9};
      iss_we_odd = 1'b1;
      iss_rt_odd = 7'd20;
      tick();
      wb_even = pkt(7'd20, 128'h99);
      tick();
      clr_taps();
      iss_we_odd = 1'b0;
      src_addr = {7'd20, 7'd6, 7'd7, 7'd8, 7'd9};
      #1 check("set_wins_stall", stall, 1);
      rd_valid = 1'b0;
      #1 check("no_valid_no_stall", stall, 0);
      wb_odd = pkt(7'd20, 128'h98);
      tick();
      wb_odd = '0;
      rd_valid = 1'b1;
      #1 check("wb_clear_no_stall", stall, 0);
      tick();
      check("wb_clear_ra_e_rf", ra_rd_even, 128'h11);
      src_addr = {7'd10, 7'd6, 7'd7, 7'd8, 7'd9};
      #1 check("pre_reset_stall", stall, 1);
      reset = 1'b0;
      #1 check("async_reset_stall", stall, 0);
      check("async_reset_op_valid", op_valid, 0);
      check("async_reset_ra_e", ra_rd_even, 0);
      tick();
      reset = 1'b1;
      rf_data[4*Q +: Q] = 128'h77;
      #1 check("post_reset_stall", stall, 0);
      tick();
      check("post_reset_ra_e", ra_rd_even, 128'h77);
      check("post_reset_op_valid", op_valid, 1);
`ifdef BYPASS_PERF_CNT_EN
      src_addr = {7'd5, 7'd6, 7'd7, 7'd8, 7'd9};
      iss_we_even = 1'b1;
      iss_rt_even = 7'd30;
      tick();
      iss_we_even = 1'b0;
      src_addr = {7'd30, 7'd31, 7'd7, 7'd8, 7'd9};
      tick();
      tick();
      tick();
      check("perf_stall_cycles_3", stall_cycles, 3);
      fwe[1*PW +: PW] = pkt(7'd30, 128'h301);
      fwo[0 +: PW] = pkt(7'd31, 128'h311);
      tick();
      clr_taps();
      check("perf_stall_cycles", stall_cycles, 3);
      check("perf_fwd_hits", fwd_hits, 2);
      check("perf_ra_e", ra_rd_even, 128'h301);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
